// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin arbiter/sequencer sharing one signed 8x8 multiplier.
// Ports: clk/rst_n; req_* request channels; resp_* response channels; mul_* multiplier side; busy.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  WAIT cycles without mul_done before an error response (>=2)
//
// Ports:
//   req_valid/req_ready   per-requester request handshake (ready one-hot or zero)
//   req_x/req_z           packed signed operands, requester i at [8i+7:8i]
//   resp_valid/resp_ready per-requester response handshake (valid one-hot or zero)
//   resp_y/resp_err       shared product and timeout flag
//   mul_start/mul_x/mul_z registered multiplier drive
//   mul_y/mul_done        multiplier result and completion
//   busy                  high whenever the FSM is not IDLE

module mult_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_x,
    input  logic [8*N_REQ-1:0]   req_z,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [15:0]          resp_y,
    output logic                 resp_err,
    output logic                 mul_start,
    output logic [7:0]           mul_x,
    output logic [7:0]           mul_z,
    input  logic [15:0]          mul_y,
    input  logic                 mul_done,
    output logic                 busy
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      x_q, x_d;
    logic [7:0]      z_q, z_d;
    logic            start_q, start_d;
    logic [15:0]     y_q, y_d;
    logic            err_q, err_d;

    logic [GW-1:0]   pick;
    logic            pick_vld;
    logic [GW:0]     rr_sum;
    logic [GW-1:0]   rr_idx;
    logic [7:0]      sel_x;
    logic [7:0]      sel_z;
    logic            accept;

    // Search from last_q+1 upward with wrap; the one-bit-wider sum
    // keeps the wrap correct for non-power-of-two N_REQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        rr_sum   = '0;
        rr_idx   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            rr_sum = {1'b0, last_q} + (GW+1)'(off);
            if (rr_sum >= (GW+1)'(N_REQ)) begin
                rr_sum = rr_sum - (GW+1)'(N_REQ);
            end
            rr_idx = rr_sum[GW-1:0];
            if (!pick_vld && req_valid[rr_idx]) begin
                pick_vld = 1'b1;
                pick     = rr_idx;
            end
        end
    end

    always_comb begin
        sel_x = '0;
        sel_z = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == GW'(i)) begin
                sel_x = req_x[8*i +: 8];
                sel_z = req_z[8*i +: 8];
            end
        end
    end

    assign accept = (state_q == S_IDLE) && pick_vld;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[pick] = 1'b1;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == S_RESP) begin
            resp_valid[gnt_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        z_d     = z_q;
        start_d = start_q;
        y_d     = y_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    gnt_d   = pick;
                    x_d     = sel_x;
                    z_d     = sel_z;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_d = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    y_d     = mul_y;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    // Multiplier never answered: report an error, zero product.
                    y_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                // Only the granted requester's ready completes the response.
                if (resp_ready[gnt_q]) begin
                    last_d  = gnt_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(N_REQ-1);
            cnt_q   <= '0;
            x_q     <= '0;
            z_q     <= '0;
            start_q <= 1'b0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            z_q     <= z_d;
            start_q <= start_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign mul_start = start_q;
    assign mul_x     = x_q;
    assign mul_z     = z_q;
    assign resp_y    = y_q;
    assign resp_err  = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb_mult_rr_arbiter: randomized scoreboard bench for mult_rr_arbiter.
// Reference grant/product model in plain arithmetic; monitor pops on response handshakes.

module tb_mult_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [8*N-1:0]   req_x;
    logic [8*N-1:0]   req_z;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready = '1;
    logic [15:0]      resp_y;
    logic             resp_err;
    logic             mul_start;
    logic [7:0]       mul_x;
    logic [7:0]       mul_z;
    logic [15:0]      mul_y;
    logic             mul_done;
    logic             busy;

    typedef struct {
        int          id;
        logic [15:0] y;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          model_last = N-1;
    bit          stuck = 1'b0;
    int          mlat = 1;
    int          mcnt = 0;
    logic [15:0] mprod = '0;
    logic [7:0]  x_op [N];
    logic [7:0]  z_op [N];

    mult_rr_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_z      (req_z),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_err   (resp_err),
        .mul_start  (mul_start),
        .mul_x      (mul_x),
        .mul_z      (mul_z),
        .mul_y      (mul_y),
        .mul_done   (mul_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_x = '0;
        req_z = '0;
        for (int i = 0; i < N; i++) begin
            req_x[8*i +: 8] = x_op[i];
            req_z[8*i +: 8] = z_op[i];
        end
    end

    // Multiplier stand-in: done pulses mlat cycles after start is seen.
    assign mul_done = (mcnt == 1);
    assign mul_y    = mprod;

    always @(posedge clk) begin
        if (mul_start) begin
            mprod <= $signed(mul_x) * $signed(mul_z);
            mcnt  <= stuck ? 0 : mlat;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_grant(input logic [N-1:0] m, input int last);
        for (int off = 1; off <= N; off++) begin
            if (m[(last + off) % N]) return (last + off) % N;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] m, input int hold);
        int          eg;
        int          c;
        int          p;
        byte         xs;
        byte         zs;
        exp_t        e;
        logic [N-1:0] rv;
        logic [15:0] ry;
        logic        re;
        resp_ready = '1;
        req_valid  = m;
        #1;
        eg = exp_grant(m, model_last);
        c  = 0;
        while (req_ready == '0 && c < 10) begin
            step();
            c++;
        end
        chk("req_ready", 32'(req_ready), 32'(1) << eg);
        xs = x_op[eg];
        zs = z_op[eg];
        p  = xs * zs;
        e.id  = eg;
        e.err = stuck;
        e.y   = stuck ? 16'h0 : p[15:0];
        sbq.push_back(e);
        step();
        chk("mul_start_hi", 32'(mul_start), 1);
        chk("mul_x", 32'(mul_x), 32'(x_op[eg]));
        chk("mul_z", 32'(mul_z), 32'(z_op[eg]));
        chk("busy_hi", 32'(busy), 1);
        chk("ready_blocked", 32'(req_ready), 0);
        if (hold > 0) resp_ready = ~(N'(1) << eg);
        step();
        chk("mul_start_lo", 32'(mul_start), 0);
        c = 1;
        while (resp_valid == '0 && c < 40) begin
            step();
            c++;
        end
        chk("resp_lat", c, stuck ? TO + 1 : mlat + 1);
        chk("resp_valid", 32'(resp_valid), 32'(1) << eg);
        rv = resp_valid;
        ry = resp_y;
        re = resp_err;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("bp_valid", 32'(resp_valid), 32'(rv));
            chk("bp_y", 32'(resp_y), 32'(ry));
            chk("bp_err", 32'(resp_err), 32'(re));
            chk("bp_ready", 32'(req_ready), 0);
        end
        resp_ready = '1;
        step();
        chk("resp_clr", 32'(resp_valid), 0);
        chk("busy_lo", 32'(busy), 0);
        req_valid  = '0;
        model_last = eg;
    endtask

    always @(negedge clk) begin
        if (rst_n && (resp_valid & resp_ready) != '0) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got resp_valid %0h expected none",
                         resp_valid);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_id", 32'(resp_valid), 32'(1) << mon_e.id);
                chk("sb_y", 32'(resp_y), 32'(mon_e.y));
                chk("sb_err", 32'(resp_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            x_op[i] = 8'(i * 37 + 3);
            z_op[i] = 8'(8'hF0 - i * 29);
        end
        repeat (3) step();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_y", 32'(resp_y), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_mul_start", 32'(mul_start), 0);
        chk("rst_mul_x", 32'(mul_x), 0);
        chk("rst_mul_z", 32'(mul_z), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step();

        // Fairness: all requesters pending, two full rounds.
        for (int r = 0; r < 2 * N; r++) run_op('1, 0);

        // Single request on requester 1: 5 * -3.
        x_op[1] = 8'd5;
        z_op[1] = 8'hFD;
        run_op(4'b0010, 0);

        // Extremes through requester 0.
        x_op[0] = 8'h80; z_op[0] = 8'h80; run_op(4'b0001, 0);
        x_op[0] = 8'h7F; z_op[0] = 8'h80; run_op(4'b0001, 0);
        x_op[0] = 8'h00; z_op[0] = 8'd77; run_op(4'b0001, 0);

        // Backpressure with another request pending.
        run_op(4'b1010, 5);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) begin
                x_op[i] = 8'($urandom);
                z_op[i] = 8'($urandom);
            end
            run_op(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3));
        end

        // Timeout with done stuck low.
        stuck = 1'b1;
        x_op[1] = 8'd9;
        z_op[1] = 8'd9;
        run_op(4'b0010, 0);
        stuck = 1'b0;

        // Reset in the middle of WAIT of a slow operation.
        mlat = 4;
        x_op[2] = 8'h5A;
        z_op[2] = 8'hC3;
        req_valid = 4'b0100;
        #1;
        chk("rw_req_ready", 32'(req_ready), 32'h4);
        step();
        step();
        step();
        chk("rw_busy", 32'(busy), 1);
        chk("rw_no_resp", 32'(resp_valid), 0);
        #2;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("ar_req_ready", 32'(req_ready), 0);
        chk("ar_resp_valid", 32'(resp_valid), 0);
        chk("ar_resp_y", 32'(resp_y), 0);
        chk("ar_resp_err", 32'(resp_err), 0);
        chk("ar_mul_start", 32'(mul_start), 0);
        chk("ar_mul_x", 32'(mul_x), 0);
        chk("ar_mul_z", 32'(mul_z), 0);
        chk("ar_busy", 32'(busy), 0);
        step();
        step();
        rst_n = 1'b1;
        model_last = N - 1;
        mlat = 1;
        step();
        run_op('1, 0);
        run_op(4'b0100, 0);
        run_op('1, 0);

        repeat (3) step();
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_rr_arbiter.md
# mult_rr_arbiter

Round-robin arbiter and sequencer that shares one single-cycle signed 8x8 multiplier among N_REQ requesters. Each requester uses a valid/ready request channel with its own operands and a valid/ready response channel. The block drives the multiplier's start/x/z, captures y when done is seen, and returns the 16-bit product to the granted requester. It guards against a missing done with a timeout. It sits between the processing-element front ends and the shared `direct_multiplier` instance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 8, max WAIT cycles without mul_done before an error response (>=2)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_x  in  8*N_REQ  signed operand x; requester i at bits [8i+7:8i]
- req_z  in  8*N_REQ  signed operand z; same packing
- resp_valid  out  N_REQ  response valid, one-hot or zero
- resp_ready  in  N_REQ  per-requester response accept
- resp_y  out  16  product (two's complement), shared by all requesters
- resp_err  out  1  response carries a timeout error (resp_y = 0)
- mul_start  out  1  multiplier start, registered
- mul_x, mul_z  out  8  multiplier operands, registered
- mul_y  in  16  multiplier result
- mul_done  in  1  multiplier done
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is high, the grant g is the first requester with req_valid high, searching from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready[g] is driven combinationally (state==IDLE && req_valid[g]); all other bits are 0.
  - On the handshake edge: latch g, mul_x<=req_x[g], mul_z<=req_z[g], mul_start<=1; go to ISSUE.
- **ISSUE**
  - mul_start is high for exactly this one cycle.
  - Next edge: mul_start<=0, clear the timeout counter, go to WAIT.
- **WAIT**
  - If mul_done=1: capture resp_y<=mul_y, resp_err<=0, go to RESP.
  - Else the counter increments. When the counter reaches TIMEOUT-1 without done: resp_y<=0, resp_err<=1, go to RESP.
- **RESP**
  - resp_valid[g]=1, driven from the state register and g.
  - On resp_ready[g]: last_grant<=g, resp_valid clears, go to IDLE.
  - resp_ready on non-granted bits is ignored.
- mul_x/mul_z hold their values after the issue, until the next accept.
- The product is the signed 16-bit result from the multiplier, passed through unmodified: no truncation and no sign rework. Examples: -128*-128 = 0x4000; 127*-128 = 0xC080.
- Only one operation is in flight. No new request is accepted in ISSUE, WAIT or RESP; req_ready is all-zero in those states.
- A requester may drop req_valid before it is granted without effect. Once accepted, the operation always completes with a response.

## Timing
- Reset values (all outputs): req_ready=0, resp_valid=0, resp_y=0, resp_err=0, mul_start=0, mul_x=0, mul_z=0, busy=0, state=IDLE, last_grant=N_REQ-1 (so req 0 has top priority after reset).
- Cycle numbering is relative to the accept edge k:
  - mul_start is high between k and k+1.
  - The multiplier asserts done after k+1.
  - The result is captured at k+2.
  - resp_valid is high from k+2.
  - The earliest response handshake is at k+3.
  - The earliest next accept is at k+4.
- Minimum 4 cycles per operation.
- Backpressure: while resp_valid is high and resp_ready[g] is low, resp_valid, resp_y, resp_err and g are held stable indefinitely.
- Timeout: with mul_done stuck at 0, the error is captured TIMEOUT cycles after entering WAIT.
- Asynchronous reset in any state drops the in-flight operation, forces all outputs to their reset values immediately, and returns the FSM to IDLE. The requester must reissue.

## Test plan
- Single request: req1 x=5, z=-3, resp_ready held 1. Required: req_ready[1] pulses once; mul_start high for 1 cycle with mul_x=0x05, mul_z=0xFD; resp_valid[1] at k+2 with resp_y=0xFFF1, resp_err=0; back in IDLE at k+3.
- Extremes through req0: (-128,-128) -> 0x4000; (127,-128) -> 0xC080; (0,77) -> 0x0000.
- Fairness, first pass: all four req_valid held high from reset, distinct operands. Required: grant order 0,1,2,3; each response matches its own operands.
- Fairness, wrap: continue with all four req_valid held high after the first pass. Required: order 0,1,2,3 again, and no requester is granted twice before the others.
- Backpressure: hold resp_ready low for 5 cycles in RESP. Required: resp_valid/resp_y stable; req_ready=0 despite a pending req_valid; a single response on release.
- Timeout: tie mul_done=0. Required: resp_err=1 and resp_y=0 after TIMEOUT (8) WAIT cycles. Then assert rst_n low during WAIT of a normal operation. Required: all outputs 0 immediately, FSM in IDLE, and the next request is served correctly.
